// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that steers one of N requesters through a shared mux
// into a single registered valid/ready output stage.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_vld,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_rdy,
  output logic                 out_vld,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_rdy
);
  localparam int SW = $clog2(N);
  logic [SW-1:0] last;
  logic [SW-1:0] win;
  logic          found;
  logic          load_en;
  logic          grant;
  // Scan from the requester after the last winner, wrapping around.
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++)
      if (!found && req_vld[(int'(last) + k) % N]) begin
        found = 1'b1;
        win = SW'((int'(last) + k) % N);
      end
  end
  assign load_en = !out_vld || out_rdy;
  assign grant   = load_en && found && !rst;
  assign req_rdy = grant ? N'(1) << win : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      last     <= SW'(N - 1);
    end else if (grant) begin
      out_vld  <= 1'b1;
      out_data <= req_data[win*W +: W];
      out_src  <= win;
      last     <= win;
    end else if (load_en) begin
      out_vld  <= 1'b0;
    end
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and controller for a shared N:1 multiplexer.
- N requesters compete for one output channel. The block selects one winner per transfer, drives the mux select from that choice, and registers the steered data into a single valid/ready output stage.
- It is the sequencing logic that turns a bare select-driven mux into a fair, backpressure-aware shared resource.

Parameters:
- N, 4, number of requesters (≥2); select width is $clog2(N).
- W, 8, data width per requester.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, reset, synchronous and active-high.
- req_vld, input, N, requester i has data valid.
- req_data, input, N*W, requester i data in bits [i*W +: W].
- req_rdy, output, N, one-hot or zero; requester i's data is accepted this cycle.
- out_vld, output, 1, output register holds valid data.
- out_data, output, W, registered data of the current winner.
- out_src, output, $clog2(N), index of the requester whose data is in out_data.
- out_rdy, input, 1, downstream accepts out_data this cycle.

Behaviour:
- Reset (clk edge with rst=1):
  - out_vld=0, out_data=0, out_src=0.
  - Priority pointer last=N-1, so requester 0 has highest priority after reset.
  - rst overrides all other events in the same cycle.
  - Data held in the output register at reset is discarded; no req_rdy is asserted in a reset cycle.
- Load condition: load_en = !out_vld || out_rdy (register empty, or being drained this cycle).
- Arbitration (combinational, evaluated only when load_en=1 and at least one req_vld bit is set):
  - winner = first i with req_vld[i]=1, scanning from (last+1) mod N upward with wrap-around.
  - req_rdy[winner]=1; all other req_rdy bits are 0.
  - If load_en=0 or req_vld==0, req_rdy=0.
  - req_rdy depends combinationally on req_vld and out_rdy. Requesters must not make req_vld depend on req_rdy.
- On clk edge with a grant:
  - out_data <= req_data[winner], out_src <= winner, out_vld <= 1, last <= winner.
- On clk edge with load_en=1 and no grant:
  - out_vld <= 0; out_data and out_src hold their old values; last unchanged.
- On clk edge with load_en=0 (out_vld=1, out_rdy=0):
  - Hold: out_vld, out_data and out_src stay stable; last unchanged.
- Latency and throughput:
  - 1 cycle from grant to out_vld.
  - Full throughput of 1 transfer/cycle when out_rdy stays high.
- Simultaneous drain and load: a drain (out_vld & out_rdy) and a new grant in the same cycle produce back-to-back valid data with no bubble.
- Fairness: with all N requesters continuously valid and out_rdy=1, grants rotate 0,1,…,N-1,0,… Each requester is granted exactly once per N consecutive grants.
- Non-contiguous requests: the pointer skips requesters with req_vld=0 (e.g. last=1, req_vld=4'b1001 → winner 3).
- Wrap-around: last=N-1 with req_vld[0]=1 → winner 0.
- Single requester: it wins every eligible cycle regardless of pointer position.
- Sole-source rule: the mux select is driven only from the arbitration result. No other path writes out_data.
- Invariants for assertions:
  - $onehot0(req_rdy).
  - req_rdy & ~req_vld == 0.
  - out_data and out_src are stable while out_vld && !out_rdy.

Test Plan:
1. Reset mid-transfer: N=4, load req_data[2]=8'hA5 with out_rdy=0, then assert rst for 1 cycle → next cycle out_vld=0, out_data=0, req_rdy=0; after release with req_vld=4'b1111, first winner is 0.
2. Full contention: req_vld=4'b1111, req_data[i]=8'h10+i, out_rdy=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3 and out_data 10,11,12,13,10,11,12,13, with out_vld=1 on every cycle after the first.
3. Backpressure: out_vld=1 holding 8'h11 (src 1), out_rdy=0 for 3 cycles with req_vld=4'b1111 → req_rdy=0, out_data stays 8'h11; on the cycle out_rdy=1, req_rdy=4'b0100 and 8'h12 appears next cycle.
4. Sparse and wrap-around: last=3, req_vld=4'b1010 → winner 1; then req_vld=4'b1001 → winner 3; then req_vld=4'b0001 → winner 0.
5. Idle gap: out_vld=1, out_rdy=1, req_vld=0 → next cycle out_vld=0; assert req_vld=4'b0100 → req_rdy=4'b0100 in the same cycle, and out_vld=1 with out_src=2 one cycle later.
6. Random regression: random req_vld, data and out_rdy over 10k cycles against a scoreboard model → the output stream matches the model's ordering, no data is lost or duplicated, and all invariants hold.
